// File: rtl/mainfsm.sv
// Multicycle processor main controller: sequences fetch, decode, memory, execute
// and branch phases, and decodes the current state into datapath control strobes.
module mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       InstrDone,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t state_r;
  state_t next_s;
  logic   legal_s;
  logic   unused_s;

  // Funct[4:1] carry ALU/addressing detail consumed elsewhere in the datapath.
  assign unused_s = ^Funct[4:1];
  assign State    = state_r;

  // State register; reset forces FETCH immediately, regardless of clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; unused encodings recover to FETCH.
  always_comb begin
    next_s = FETCH;
    case (state_r)
      FETCH:  next_s = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          2'b00:   next_s = Funct[5] ? EXECI : EXECR;
          2'b01:   next_s = MEMADR;
          2'b10:   next_s = BRANCH;
          default: next_s = FETCH;
        endcase
      end
      MEMADR: next_s = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  next_s = MemReady ? MEMWB : MEMRD;
      MEMWR:  next_s = MemReady ? FETCH : MEMWR;
      EXECR:  next_s = ALUWB;
      EXECI:  next_s = ALUWB;
      MEMWB:  next_s = FETCH;
      ALUWB:  next_s = FETCH;
      BRANCH: next_s = FETCH;
      default: next_s = FETCH;
    endcase
  end

  // Moore-style control decode; FETCH strobes follow MemReady so the PC
  // advances once per fetch no matter how many wait cycles precede it.
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    legal_s   = 1'b1;
    case (state_r)
      FETCH: begin
        IRWrite   = MemReady;
        NextPC    = MemReady;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: begin
        ALUSrcA = 2'b00;
        ALUSrcB = 2'b01;
        ALUOp   = 1'b0;
      end
      MEMRD: begin
        AdrSrc    = 1'b1;
        ResultSrc = 2'b00;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECR: begin
        ALUSrcA = 2'b00;
        ALUSrcB = 2'b00;
        ALUOp   = 1'b1;
      end
      EXECI: begin
        ALUSrcA = 2'b00;
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      ALUWB: begin
        ResultSrc = 2'b00;
        RegW      = 1'b1;
      end
      BRANCH: begin
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        ALUOp     = 1'b0;
        Branch    = 1'b1;
      end
      default: legal_s = 1'b0;
    endcase
    if (legal_s && (next_s == FETCH) && (state_r != FETCH)) begin
      InstrDone = 1'b1;
    end else begin
      InstrDone = 1'b0;
    end
  end

endmodule

// File: tb/tb_mainfsm.sv
// Directed bench for mainfsm: a vector table walking every instruction class,
// plus hand sequences for reset behaviour.
module tb_mainfsm;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, InstrDone;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] State;
  logic [13:0] act_out;

  int passed;
  int total;

  mainfsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .Branch(Branch), .ALUOp(ALUOp), .InstrDone(InstrDone), .State(State)
  );

  // Bundle order: IRWrite AdrSrc ALUSrcA ALUSrcB ResultSrc NextPC RegW MemW Branch ALUOp InstrDone
  assign act_out = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                    NextPC, RegW, MemW, Branch, ALUOp, InstrDone};

  localparam logic [13:0] O_FETCH_WAIT = {1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] O_FETCH_RDY  = {1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] O_DECODE     = {1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] O_DEC_UNDEF  = {1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [13:0] O_MEMADR     = {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] O_MEMRD      = {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] O_MEMWB      = {1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [13:0] O_MEMWR_WAIT = {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] O_MEMWR_RDY  = {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic [13:0] O_EXECR      = {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [13:0] O_EXECI      = {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [13:0] O_ALUWB      = {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [13:0] O_BRANCH     = {1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        mr;
    logic [3:0]  st;
    logic [13:0] out;
  } vec_t;

  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic [1:0] op, input logic [5:0] funct, input logic mr,
                     input logic [3:0] st, input logic [13:0] out);
    vec_t v;
    v.op = op; v.funct = funct; v.mr = mr; v.st = st; v.out = out;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] st, input logic [13:0] out);
    total++;
    if (State === st) passed++;
    else $display("FAIL %s state: got %0d expected %0d", name, State, st);
    total++;
    if (act_out === out) passed++;
    else $display("FAIL %s outputs: got %b expected %b", name, act_out, out);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset = 1'b1; Op = 2'b00; Funct = 6'b000000; MemReady = 1'b0;

    // Reset state: outputs hold FETCH values, IRWrite/NextPC follow MemReady.
    @(negedge clk);
    #1 check("reset_mr0", 4'd0, O_FETCH_WAIT);
    MemReady = 1'b1;
    #1 check("reset_mr1", 4'd0, O_FETCH_RDY);
    @(negedge clk);
    check("reset_held_over_edge", 4'd0, O_FETCH_RDY);

    // Data-processing immediate, then register form.
    add(2'b00, 6'b100000, 1'b1, 4'd0, O_FETCH_RDY);
    add(2'b00, 6'b100000, 1'b1, 4'd1, O_DECODE);
    add(2'b00, 6'b100000, 1'b1, 4'd7, O_EXECI);
    add(2'b00, 6'b100000, 1'b1, 4'd8, O_ALUWB);
    add(2'b00, 6'b000000, 1'b1, 4'd0, O_FETCH_RDY);
    add(2'b00, 6'b000000, 1'b1, 4'd1, O_DECODE);
    add(2'b00, 6'b000000, 1'b1, 4'd6, O_EXECR);
    add(2'b00, 6'b000000, 1'b1, 4'd8, O_ALUWB);
    // LDR with two MEMRD wait cycles.
    add(2'b01, 6'b000001, 1'b1, 4'd0, O_FETCH_RDY);
    add(2'b01, 6'b000001, 1'b1, 4'd1, O_DECODE);
    add(2'b01, 6'b000001, 1'b1, 4'd2, O_MEMADR);
    add(2'b01, 6'b000001, 1'b0, 4'd3, O_MEMRD);
    add(2'b01, 6'b000001, 1'b0, 4'd3, O_MEMRD);
    add(2'b01, 6'b000001, 1'b1, 4'd3, O_MEMRD);
    add(2'b01, 6'b000001, 1'b1, 4'd4, O_MEMWB);
    // STR with three FETCH wait cycles and one MEMWR wait.
    add(2'b01, 6'b000000, 1'b0, 4'd0, O_FETCH_WAIT);
    add(2'b01, 6'b000000, 1'b0, 4'd0, O_FETCH_WAIT);
    add(2'b01, 6'b000000, 1'b0, 4'd0, O_FETCH_WAIT);
    add(2'b01, 6'b000000, 1'b1, 4'd0, O_FETCH_RDY);
    add(2'b01, 6'b000000, 1'b1, 4'd1, O_DECODE);
    add(2'b01, 6'b000000, 1'b1, 4'd2, O_MEMADR);
    add(2'b01, 6'b000000, 1'b0, 4'd5, O_MEMWR_WAIT);
    add(2'b01, 6'b000000, 1'b1, 4'd5, O_MEMWR_RDY);
    // Branch, then undefined op retiring from DECODE.
    add(2'b10, 6'b000000, 1'b1, 4'd0, O_FETCH_RDY);
    add(2'b10, 6'b000000, 1'b1, 4'd1, O_DECODE);
    add(2'b10, 6'b000000, 1'b1, 4'd9, O_BRANCH);
    add(2'b11, 6'b000000, 1'b1, 4'd0, O_FETCH_RDY);
    add(2'b11, 6'b000000, 1'b1, 4'd1, O_DEC_UNDEF);
    add(2'b11, 6'b000000, 1'b1, 4'd0, O_FETCH_RDY);

    // Release at a falling edge: the next rising edge evaluates FETCH.
    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      Op = vecs[i].op; Funct = vecs[i].funct; MemReady = vecs[i].mr;
      #1 check($sformatf("vec%0d", i), vecs[i].st, vecs[i].out);
      @(negedge clk);
    end

    // Last vector left the FSM in DECODE; drive a store into MEMWR and stall it.
    Op = 2'b01; Funct = 6'b000000; MemReady = 1'b1;
    #1 check("str2_decode", 4'd1, O_DECODE);
    @(negedge clk);
    check("str2_memadr", 4'd2, O_MEMADR);
    @(negedge clk);
    MemReady = 1'b0;
    #1 check("str2_memwr_wait", 4'd5, O_MEMWR_WAIT);
    @(posedge clk);
    #2 check("str2_memwr_still", 4'd5, O_MEMWR_WAIT);
    reset = 1'b1;
    #1 check("reset_mid_memwr", 4'd0, O_FETCH_WAIT);
    @(negedge clk);
    #1 check("reset_hold_memwr", 4'd0, O_FETCH_WAIT);

    // Reset during a MEMRD wait also returns to FETCH at once.
    reset = 1'b0; Op = 2'b01; Funct = 6'b000001; MemReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    MemReady = 1'b0;
    #1 check("ldr2_memrd_wait", 4'd3, O_MEMRD);
    reset = 1'b1;
    #1 check("reset_mid_memrd", 4'd0, O_FETCH_WAIT);
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
